display_timings_dyn: RTL and testbench

- Parametrised successor video timing generator, one pixel-clock domain.
- Produces sync, display-enable, frame and line strobes, and signed beam coordinates, with active pixels at (0,0) and blanking at negative coordinates.
- Adds a valid/ready configuration port. A new mode is validated, held in a pending register and swapped in only at the frame boundary, so no frame is ever torn.
- Also adds programmable sync polarity per mode and a programmable line interrupt. Sits between the mode-control logic and the pixel pipeline / TMDS encoder.

---
 rtl/display_timings_pkg.sv | 67 ++++++
 rtl/display_timings_cfg_check.sv | 34 +++
 rtl/display_timings_dyn.sv | 176 +++++++++++++++++
 tb/tb_display_timings_dyn.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_timings_pkg.sv
// display_timings_pkg: shared configuration record, the 640x480 reset mode
// and the helper that turns a configuration into signed beam landmarks.
package display_timings_pkg;

    // Storage width of every configuration field; port fields are zero-extended.
    localparam int CFG_FW = 16;

    // Signed width of derived landmarks. Wide enough for CORDW+2 up to CORDW=30.
    localparam int DW = 32;

    typedef struct packed {
        logic [CFG_FW-1:0] h_res;
        logic [CFG_FW-1:0] h_fp;
        logic [CFG_FW-1:0] h_sync;
        logic [CFG_FW-1:0] h_bp;
        logic [CFG_FW-1:0] v_res;
        logic [CFG_FW-1:0] v_fp;
        logic [CFG_FW-1:0] v_sync;
        logic [CFG_FW-1:0] v_bp;
        logic              h_pol;   // 1 = positive sync
        logic              v_pol;
    } timing_cfg_t;

    typedef struct packed {
        logic signed [DW-1:0] h_sta;   // first blanking column (negative)
        logic signed [DW-1:0] hs_sta;  // sync asserted for hs_sta < x <= hs_end
        logic signed [DW-1:0] hs_end;
        logic signed [DW-1:0] ha_end;  // last active column
        logic signed [DW-1:0] v_sta;
        logic signed [DW-1:0] vs_sta;
        logic signed [DW-1:0] vs_end;
        logic signed [DW-1:0] va_end;
    } timing_derived_t;

    localparam timing_cfg_t CFG_640X480 = '{
        h_res:  16'd640,
        h_fp:   16'd16,
        h_sync: 16'd96,
        h_bp:   16'd48,
        v_res:  16'd480,
        v_fp:   16'd10,
        v_sync: 16'd2,
        v_bp:   16'd33,
        h_pol:  1'b0,
        v_pol:  1'b0
    };

    // Zero-extend a configuration field to the derived width.
    function automatic logic [DW-1:0] zext(input logic [CFG_FW-1:0] v);
        return {{(DW-CFG_FW){1'b0}}, v};
    endfunction

    // Blanking sits at negative coordinates, so the line starts at -(fp+sync+bp).
    function automatic timing_derived_t derive_timing(input timing_cfg_t c);
        timing_derived_t d;
        d.h_sta  = -$signed(zext(c.h_fp) + zext(c.h_sync) + zext(c.h_bp));
        d.hs_sta = d.h_sta + $signed(zext(c.h_fp));
        d.hs_end = d.hs_sta + $signed(zext(c.h_sync));
        d.ha_end = $signed(zext(c.h_res)) - 32'sd1;
        d.v_sta  = -$signed(zext(c.v_fp) + zext(c.v_sync) + zext(c.v_bp));
        d.vs_sta = d.v_sta + $signed(zext(c.v_fp));
        d.vs_end = d.vs_sta + $signed(zext(c.v_sync));
        d.va_end = $signed(zext(c.v_res)) - 32'sd1;
        return d;
    endfunction

endpackage

// File: rtl/display_timings_cfg_check.sv
// display_timings_cfg_check: combinational legality check of an offered mode.
// A mode is legal when it has non-zero active area and sync widths and each
// axis total still fits the positive range of a CORDW-bit signed coordinate.
module display_timings_cfg_check
    import display_timings_pkg::*;
#(
    parameter int CORDW = 16
) (
    input  timing_cfg_t cfg,
    output logic        ok
);

    logic [DW-1:0] h_sum_s;
    logic [DW-1:0] v_sum_s;
    logic [DW-1:0] lim_s;
    logic          unused_pol_s;

    // Polarity never affects legality.
    assign unused_pol_s = cfg.h_pol ^ cfg.v_pol;

    // Evaluate the zero-field and total-length rules.
    always_comb begin
        h_sum_s = zext(cfg.h_res) + zext(cfg.h_fp) + zext(cfg.h_sync) + zext(cfg.h_bp);
        v_sum_s = zext(cfg.v_res) + zext(cfg.v_fp) + zext(cfg.v_sync) + zext(cfg.v_bp);
        lim_s   = (32'd1 << (CORDW - 1)) - 32'd1;
        ok      = (cfg.h_res  != {CFG_FW{1'b0}}) &&
                  (cfg.v_res  != {CFG_FW{1'b0}}) &&
                  (cfg.h_sync != {CFG_FW{1'b0}}) &&
                  (cfg.v_sync != {CFG_FW{1'b0}}) &&
                  (h_sum_s <= lim_s) &&
                  (v_sum_s <= lim_s);
    end

endmodule

// File: rtl/display_timings_dyn.sv
// display_timings_dyn: run-time reconfigurable video timing generator.
// A new mode is accepted over a valid/ready port into a single pending slot
// and only swapped in on the last pixel of a frame, so frames never tear.
module display_timings_dyn
    import display_timings_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int RESW  = 12,
    parameter int HPW   = 8,
    parameter int VPW   = 6
) (
    input  logic                    i_pix_clk,
    input  logic                    i_rst,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [RESW-1:0]         i_cfg_h_res,
    input  logic [RESW-1:0]         i_cfg_v_res,
    input  logic [HPW-1:0]          i_cfg_h_fp,
    input  logic [HPW-1:0]          i_cfg_h_sync,
    input  logic [HPW-1:0]          i_cfg_h_bp,
    input  logic [VPW-1:0]          i_cfg_v_fp,
    input  logic [VPW-1:0]          i_cfg_v_sync,
    input  logic [VPW-1:0]          i_cfg_v_bp,
    input  logic                    i_cfg_h_pol,
    input  logic                    i_cfg_v_pol,
    input  logic signed [CORDW-1:0] i_irq_line,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic                    o_de,
    output logic                    o_frame,
    output logic                    o_line,
    output logic                    o_line_irq,
    output logic                    o_cfg_applied,
    output logic                    o_cfg_err,
    output logic signed [CORDW-1:0] o_sx,
    output logic signed [CORDW-1:0] o_sy
);

    localparam timing_derived_t RST_D = derive_timing(CFG_640X480);
    localparam logic signed [CORDW-1:0] ONE = {{(CORDW-1){1'b0}}, 1'b1};

    timing_cfg_t          active_r;
    timing_cfg_t          pending_r;
    timing_cfg_t          cfg_in_s;
    timing_derived_t      act_d_s;
    timing_derived_t      pend_d_s;
    logic                 cfg_ready_r;   // high while the pending slot is empty
    logic                 applied_r;
    logic                 err_r;
    logic                 cfg_ok_s;
    logic                 accept_s;
    logic                 offer_bad_s;
    logic                 line_end_s;
    logic                 frame_end_s;
    logic                 apply_s;
    logic                 unused_pend_s;
    logic signed [CORDW-1:0] sx_r;
    logic signed [CORDW-1:0] sy_r;
    logic signed [DW-1:0]    sx_w_s;
    logic signed [DW-1:0]    sy_w_s;

    // Gather the port fields into one configuration record.
    always_comb begin
        cfg_in_s        = CFG_640X480;
        cfg_in_s.h_res  = CFG_FW'(i_cfg_h_res);
        cfg_in_s.v_res  = CFG_FW'(i_cfg_v_res);
        cfg_in_s.h_fp   = CFG_FW'(i_cfg_h_fp);
        cfg_in_s.h_sync = CFG_FW'(i_cfg_h_sync);
        cfg_in_s.h_bp   = CFG_FW'(i_cfg_h_bp);
        cfg_in_s.v_fp   = CFG_FW'(i_cfg_v_fp);
        cfg_in_s.v_sync = CFG_FW'(i_cfg_v_sync);
        cfg_in_s.v_bp   = CFG_FW'(i_cfg_v_bp);
        cfg_in_s.h_pol  = i_cfg_h_pol;
        cfg_in_s.v_pol  = i_cfg_v_pol;
    end

    display_timings_cfg_check #(
        .CORDW (CORDW)
    ) u_cfg_check (
        .cfg (cfg_in_s),
        .ok  (cfg_ok_s)
    );

    assign act_d_s  = derive_timing(active_r);
    assign pend_d_s = derive_timing(pending_r);

    // Only the start point of the pending mode is needed before it becomes active.
    assign unused_pend_s = ^{pend_d_s.hs_sta, pend_d_s.hs_end, pend_d_s.ha_end,
                             pend_d_s.vs_sta, pend_d_s.vs_end, pend_d_s.va_end};

    assign sx_w_s = {{(DW-CORDW){sx_r[CORDW-1]}}, sx_r};
    assign sy_w_s = {{(DW-CORDW){sy_r[CORDW-1]}}, sy_r};

    assign line_end_s  = (sx_w_s == act_d_s.ha_end);
    assign frame_end_s = line_end_s && (sy_w_s == act_d_s.va_end);

    // Apply only a config that was already pending before this frame-end edge;
    // one captured on the frame-end edge itself therefore waits a full frame.
    assign apply_s     = frame_end_s && !cfg_ready_r;
    assign accept_s    = i_cfg_valid && cfg_ready_r && cfg_ok_s;
    assign offer_bad_s = i_cfg_valid && !cfg_ok_s;

    // Handshake, pending slot and active mode registers.
    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            active_r    <= CFG_640X480;
            pending_r   <= CFG_640X480;
            cfg_ready_r <= 1'b1;
            applied_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            err_r     <= offer_bad_s;
            applied_r <= apply_s;
            if (apply_s) begin
                active_r    <= pending_r;
                cfg_ready_r <= 1'b1;
            end else if (accept_s) begin
                pending_r   <= cfg_in_s;
                cfg_ready_r <= 1'b0;
            end else begin
                cfg_ready_r <= cfg_ready_r;
            end
        end
    end

    // Beam counters; a mode swap restarts them at the new mode's blanking origin.
    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            sx_r <= RST_D.h_sta[CORDW-1:0];
            sy_r <= RST_D.v_sta[CORDW-1:0];
        end else if (apply_s) begin
            sx_r <= pend_d_s.h_sta[CORDW-1:0];
            sy_r <= pend_d_s.v_sta[CORDW-1:0];
        end else if (line_end_s) begin
            sx_r <= act_d_s.h_sta[CORDW-1:0];
            if (frame_end_s) begin
                sy_r <= act_d_s.v_sta[CORDW-1:0];
            end else begin
                sy_r <= sy_r + ONE;
            end
        end else begin
            sx_r <= sx_r + ONE;
        end
    end

    // Zero-latency decodes of the beam position against the active mode.
    always_comb begin
        o_hs       = 1'b0;
        o_vs       = 1'b0;
        o_de       = 1'b0;
        o_frame    = 1'b0;
        o_line     = 1'b0;
        o_line_irq = 1'b0;
        if ((sx_w_s > act_d_s.hs_sta) && (sx_w_s <= act_d_s.hs_end)) begin
            o_hs = active_r.h_pol;
        end else begin
            o_hs = ~active_r.h_pol;
        end
        if ((sy_w_s > act_d_s.vs_sta) && (sy_w_s <= act_d_s.vs_end)) begin
            o_vs = active_r.v_pol;
        end else begin
            o_vs = ~active_r.v_pol;
        end
        o_de       = !sx_r[CORDW-1] && !sy_r[CORDW-1];
        o_line     = (sx_w_s == act_d_s.h_sta);
        o_frame    = o_line && (sy_w_s == act_d_s.v_sta);
        o_line_irq = o_line && (sy_r == i_irq_line);
    end

    assign o_sx          = sx_r;
    assign o_sy          = sy_r;
    assign o_cfg_ready   = cfg_ready_r;
    assign o_cfg_applied = applied_r;
    assign o_cfg_err     = err_r;

endmodule

// File: tb/tb_display_timings_dyn.sv
// Scoreboard bench for display_timings_dyn: the stimulus process queues the
// expected frame starts, error pulses and line interrupts; a monitor pops
// and compares each time the DUT presents one of those events.
module tb_display_timings_dyn;

    logic               i_pix_clk;
    logic               i_rst;
    logic               i_cfg_valid;
    logic               o_cfg_ready;
    logic [11:0]        i_cfg_h_res;
    logic [11:0]        i_cfg_v_res;
    logic [7:0]         i_cfg_h_fp;
    logic [7:0]         i_cfg_h_sync;
    logic [7:0]         i_cfg_h_bp;
    logic [5:0]         i_cfg_v_fp;
    logic [5:0]         i_cfg_v_sync;
    logic [5:0]         i_cfg_v_bp;
    logic               i_cfg_h_pol;
    logic               i_cfg_v_pol;
    logic signed [15:0] i_irq_line;
    logic               o_hs;
    logic               o_vs;
    logic               o_de;
    logic               o_frame;
    logic               o_line;
    logic               o_line_irq;
    logic               o_cfg_applied;
    logic               o_cfg_err;
    logic signed [15:0] o_sx;
    logic signed [15:0] o_sy;

    display_timings_dyn #(
        .CORDW (16),
        .RESW  (12),
        .HPW   (8),
        .VPW   (6)
    ) dut (
        .i_pix_clk     (i_pix_clk),
        .i_rst         (i_rst),
        .i_cfg_valid   (i_cfg_valid),
        .o_cfg_ready   (o_cfg_ready),
        .i_cfg_h_res   (i_cfg_h_res),
        .i_cfg_v_res   (i_cfg_v_res),
        .i_cfg_h_fp    (i_cfg_h_fp),
        .i_cfg_h_sync  (i_cfg_h_sync),
        .i_cfg_h_bp    (i_cfg_h_bp),
        .i_cfg_v_fp    (i_cfg_v_fp),
        .i_cfg_v_sync  (i_cfg_v_sync),
        .i_cfg_v_bp    (i_cfg_v_bp),
        .i_cfg_h_pol   (i_cfg_h_pol),
        .i_cfg_v_pol   (i_cfg_v_pol),
        .i_irq_line    (i_irq_line),
        .o_hs          (o_hs),
        .o_vs          (o_vs),
        .o_de          (o_de),
        .o_frame       (o_frame),
        .o_line        (o_line),
        .o_line_irq    (o_line_irq),
        .o_cfg_applied (o_cfg_applied),
        .o_cfg_err     (o_cfg_err),
        .o_sx          (o_sx),
        .o_sy          (o_sy)
    );

    typedef struct {
        int sx;
        int sy;
        int applied;
        int period;   // cycles since previous frame start, 0 = not checked
    } frm_t;

    typedef struct {
        int sx;
        int sy;
    } irq_t;

    frm_t frame_q[$];
    irq_t irq_q[$];
    int   err_q[$];

    int   n_vec  = 0;
    int   n_miss = 0;
    bit   mon_en = 0;
    int   cyc    = 0;
    int   last_frame = 0;
    frm_t mf;
    irq_t mi;
    int   me;

    initial begin
        i_pix_clk = 1'b0;
        forever #5 i_pix_clk = ~i_pix_clk;
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int hr, input int hfp, input int hs, input int hbp,
                           input int vr, input int vfp, input int vs, input int vbp,
                           input bit hp, input bit vp);
        i_cfg_h_res  = hr[11:0];
        i_cfg_h_fp   = hfp[7:0];
        i_cfg_h_sync = hs[7:0];
        i_cfg_h_bp   = hbp[7:0];
        i_cfg_v_res  = vr[11:0];
        i_cfg_v_fp   = vfp[5:0];
        i_cfg_v_sync = vs[5:0];
        i_cfg_v_bp   = vbp[5:0];
        i_cfg_h_pol  = hp;
        i_cfg_v_pol  = vp;
    endtask

    // Present the current config fields for exactly one clock edge.
    task automatic offer;
        i_cfg_valid = 1'b1;
        @(negedge i_pix_clk);
        i_cfg_valid = 1'b0;
    endtask

    task automatic wait_applied(input int max, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge i_pix_clk);
            if (o_cfg_applied === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: no o_cfg_applied within %0d cycles, expected one", nm, max);
        end
    endtask

    task automatic wait_pos(input int x, input int y, input int max, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge i_pix_clk);
            if (o_sx == x && o_sy == y) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: beam never reached (%0d,%0d) within %0d cycles", nm, x, y, max);
        end
    endtask

    // Monitor: compare every frame start, error pulse and line interrupt with the queues.
    always @(negedge i_pix_clk) begin
        if (mon_en) begin
            cyc++;
            if (o_frame === 1'b1) begin
                if (frame_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL frame_unexpected: got frame start at (%0d,%0d), expected none", o_sx, o_sy);
                end else begin
                    mf = frame_q.pop_front();
                    chk("frame_sx", o_sx, mf.sx);
                    chk("frame_sy", o_sy, mf.sy);
                    chk("frame_applied", o_cfg_applied, mf.applied);
                    if (mf.period != 0) chk("frame_period", cyc - last_frame, mf.period);
                end
                last_frame = cyc;
            end
            if (o_cfg_applied === 1'b1 && o_frame !== 1'b1) begin
                n_vec++;
                n_miss++;
                $display("FAIL applied_off_frame: got o_cfg_applied=1 with o_frame=%b, expected o_frame=1", o_frame);
            end
            if (o_cfg_err === 1'b1) begin
                if (err_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL err_unexpected: got o_cfg_err=1, expected 0");
                end else begin
                    me = err_q.pop_front();
                    chk("err_pulse", o_cfg_err, me);
                end
            end
            if (o_line_irq === 1'b1) begin
                if (irq_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL irq_unexpected: got irq at (%0d,%0d), expected none", o_sx, o_sy);
                end else begin
                    mi = irq_q.pop_front();
                    chk("irq_sx", o_sx, mi.sx);
                    chk("irq_sy", o_sy, mi.sy);
                end
            end
        end
    end

    // Stimulus: directed mode sequence with hand-computed expectations.
    initial begin
        int hs_cnt;
        int line_at;
        int app_cnt;

        i_rst       = 1'b1;
        i_cfg_valid = 1'b0;
        i_irq_line  = 16'sd100;
        set_cfg(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        repeat (3) @(negedge i_pix_clk);

        chk("rst_sx", o_sx, -160);
        chk("rst_sy", o_sy, -45);
        chk("rst_frame", o_frame, 1);
        chk("rst_line", o_line, 1);
        chk("rst_de", o_de, 0);
        chk("rst_hs", o_hs, 1);
        chk("rst_vs", o_vs, 1);
        chk("rst_ready", o_cfg_ready, 1);
        chk("rst_applied", o_cfg_applied, 0);
        chk("rst_err", o_cfg_err, 0);

        // Default frame start, then a full 800x525 frame ending in the swap to T1.
        frame_q.push_back('{-160, -45, 0, 0});
        irq_q.push_back('{-160, 100});
        @(posedge i_pix_clk);
        mon_en = 1'b1;
        @(negedge i_pix_clk);
        i_rst = 1'b0;
        repeat (20) @(negedge i_pix_clk);

        // Rejected offer: h_sync = 0.
        err_q.push_back(1);
        set_cfg(640, 16, 0, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        offer();
        chk("reject_ready", o_cfg_ready, 1);
        repeat (10) @(negedge i_pix_clk);

        // T1: 8/2/3/1 x 4/1/1/1, hs positive, vs negative -> start (-6,-3), 98-cycle frame.
        frame_q.push_back('{-6, -3, 1, 420000});
        set_cfg(8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b0);
        offer();
        chk("accept_ready_low", o_cfg_ready, 0);
        repeat (5000) @(negedge i_pix_clk);
        chk("pending_ready_low", o_cfg_ready, 0);
        wait_applied(430000, "apply_t1");
        chk("t1_ready", o_cfg_ready, 1);
        chk("t1_hs", o_hs, 0);
        chk("t1_vs", o_vs, 1);

        // Late capture of T2 (6/1/2/1 x 3/1/1/1) on T1's frame-end pixel (7,3).
        frame_q.push_back('{-6, -3, 0, 98});
        frame_q.push_back('{-4, -3, 1, 98});
        wait_pos(7, 3, 200, "t1_frame_end");
        set_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        offer();
        chk("late_captured", o_cfg_ready, 0);
        wait_applied(300, "apply_t2");

        // 1280x720 offered mid T2 frame; applies at that frame end.
        frame_q.push_back('{-370, -30, 1, 60});
        repeat (10) @(negedge i_pix_clk);
        set_cfg(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1);
        offer();
        chk("hd_ready_low", o_cfg_ready, 0);
        repeat (30) @(negedge i_pix_clk);
        chk("hd_ready_held", o_cfg_ready, 0);
        wait_applied(100, "apply_hd");
        chk("hd_vs", o_vs, 0);
        chk("hd_de", o_de, 0);
        hs_cnt  = 0;
        line_at = 0;
        for (int i = 0; i <= 1650; i++) begin
            if (i > 0) @(negedge i_pix_clk);
            if (i < 1650 && o_hs === 1'b1) hs_cnt++;
            if (i > 0 && o_line === 1'b1 && line_at == 0) line_at = i;
        end
        chk("hd_hs_width", hs_cnt, 40);
        chk("hd_line_period", line_at, 1650);

        // Leave a config pending, then reset mid-frame.
        set_cfg(8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b0);
        offer();
        chk("pend_before_rst", o_cfg_ready, 0);
        chk("frame_q_drained", frame_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        chk("irq_once", irq_q.size(), 0);
        mon_en = 1'b0;
        repeat (5) @(negedge i_pix_clk);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_sx", o_sx, -160);
        chk("mid_rst_sy", o_sy, -45);
        chk("mid_rst_ready", o_cfg_ready, 1);
        chk("mid_rst_applied", o_cfg_applied, 0);
        chk("mid_rst_vs", o_vs, 1);
        @(negedge i_pix_clk);
        i_rst = 1'b0;
        hs_cnt  = 0;
        line_at = 0;
        app_cnt = 0;
        for (int i = 0; i <= 1700; i++) begin
            if (i > 0) @(negedge i_pix_clk);
            if (i < 800 && o_hs === 1'b0) hs_cnt++;
            if (i > 0 && o_line === 1'b1 && line_at == 0) line_at = i;
            if (o_cfg_applied === 1'b1) app_cnt++;
        end
        chk("vga_hs_low", hs_cnt, 96);
        chk("vga_line_period", line_at, 800);
        chk("no_apply_after_rst", app_cnt, 0);
        chk("ready_after_rst", o_cfg_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
